// File: rtl/state_serialiser.sv
// Serial read-out of a 4-bit present-state value: start bit, four data bits MSB-first,
// even-parity bit and stop bit, each held for BIT_CYCLES clocks. All outputs are registered.
module state_serialiser #(
   parameter int BIT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] present,
   output logic       serial_out,
   output logic       busy,
   output logic       done
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [3:0] v);
      return ^v;
   endfunction

   state_t        state_q, state_d;
   logic [3:0]    shadow_q, shadow_d;
   logic          parity_q, parity_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          serial_out_q, serial_out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          bit_end_s;

   // With one cycle per bit every edge is a bit boundary and the counter is ignored.
   assign bit_end_s = (BIT_CYCLES == 1) ? 1'b1 : (cnt_q == CNT_LAST);

   // Next-state, capture and bit-timing logic.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      parity_d = parity_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      if (state_q == S_IDLE) begin
         if (start) begin
            shadow_d = present;
            parity_d = even_parity(present);
            cnt_d    = '0;
            idx_d    = 2'd0;
            state_d  = S_START;
         end else begin
            state_d = S_IDLE;
         end
      end else if (bit_end_s) begin
         cnt_d = '0;
         case (state_q)
            S_START: begin
               state_d = S_DATA;
               idx_d   = 2'd0;
            end
            S_DATA: begin
               if (idx_q == 2'd3) begin
                  state_d = S_PARITY;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Output values for the cycle that follows the edge, derived from the next state.
   always_comb begin
      serial_out_d = 1'b1;
      busy_d       = 1'b1;
      case (state_d)
         S_IDLE:   busy_d = 1'b0;
         S_START:  serial_out_d = 1'b0;
         S_DATA:   serial_out_d = shadow_d[2'd3 - idx_d];
         S_PARITY: serial_out_d = parity_d;
         S_STOP:   serial_out_d = 1'b1;
         default: begin
            serial_out_d = 1'b1;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces the line idle and aborts any frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         shadow_q     <= 4'd0;
         parity_q     <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         serial_out_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         parity_q     <= parity_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         serial_out_q <= serial_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign serial_out = serial_out_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_state_serialiser.sv
// Randomised bench for state_serialiser at BIT_CYCLES=4 and 1, compared cycle by cycle
// against a frame-position model built from the frame format.
module tb_state_serialiser;

   logic       clock;
   logic       reset;
   logic       start;
   logic [3:0] present;
   logic       so4, busy4, done4;
   logic       so1, busy1, done1;

   int n_checks;
   int n_fail;

   // Model: position within the frame (-1 idle) and the captured value, per instance.
   int         pos4, pos1;
   logic [3:0] cap4, cap1;

   state_serialiser #(.BIT_CYCLES(4)) dut4 (
      .clock(clock), .reset(reset), .start(start), .present(present),
      .serial_out(so4), .busy(busy4), .done(done4)
   );

   state_serialiser #(.BIT_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .present(present),
      .serial_out(so1), .busy(busy1), .done(done1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line level for frame offset k: slot 0 start, 1..4 data MSB first, 5 parity, 6 stop.
   function automatic logic frame_bit(input logic [3:0] v, input int k, input int bc);
      int slot;
      slot = k / bc;
      if (slot == 0) return 1'b0;
      if (slot <= 4) return v[4 - slot];
      if (slot == 5) return v[0] ^ v[1] ^ v[2] ^ v[3];
      return 1'b1;
   endfunction

   function automatic int advance(input int pos, input int bc, input logic st);
      if (pos == -1 || pos == 7 * bc) return st ? 0 : -1;
      return pos + 1;
   endfunction

   task automatic check_inst(input string nm, input int pos, input int bc, input logic [3:0] cap,
                             input logic so, input logic bz, input logic dn);
      logic es, eb, ed;
      if (pos >= 0 && pos < 7 * bc) begin
         es = frame_bit(cap, pos, bc); eb = 1'b1; ed = 1'b0;
      end else begin
         es = 1'b1; eb = 1'b0; ed = (pos == 7 * bc);
      end
      chk({nm, "_serial"}, 32'(so), 32'(es));
      chk({nm, "_busy"},   32'(bz), 32'(eb));
      chk({nm, "_done"},   32'(dn), 32'(ed));
   endtask

   // One clock: update the model with the inputs seen at the edge, then compare.
   task automatic step();
      @(posedge clock);
      if (reset) begin
         if (pos4 == -1 || pos4 == 28) cap4 = present;
         if (pos1 == -1 || pos1 == 7)  cap1 = present;
         pos4 = advance(pos4, 4, start);
         pos1 = advance(pos1, 1, start);
      end else begin
         pos4 = -1;
         pos1 = -1;
      end
      #1;
      check_inst("bc4", pos4, 4, cap4, so4, busy4, done4);
      check_inst("bc1", pos1, 1, cap1, so1, busy1, done1);
   endtask

   task automatic pulse_frame(input logic [3:0] v, input int cycles);
      start = 1'b1;
      present = v;
      step();
      start = 1'b0;
      present = 4'b0000;
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pos4 = -1; pos1 = -1;
      cap4 = 4'd0; cap1 = 4'd0;
      start = 1'b0;
      present = 4'd0;
      reset = 1'b0;
      #12;
      chk("rst_serial4", 32'(so4), 32'd1);
      chk("rst_busy4",   32'(busy4), 32'd0);
      chk("rst_done4",   32'(done4), 32'd0);
      chk("rst_serial1", 32'(so1), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      step();

      // Frame of 1011 with present cleared after capture, then 0000 and 1111.
      pulse_frame(4'b1011, 34);
      pulse_frame(4'b0000, 34);
      pulse_frame(4'b1111, 34);

      // start held high: back-to-back frames with one idle/done cycle between.
      start = 1'b1;
      present = 4'b0110;
      for (int i = 0; i < 75; i++) step();
      start = 1'b0;
      for (int i = 0; i < 30; i++) step();

      // Reset in data bit 1 (cycle 10) of a frame.
      start = 1'b1;
      present = 4'b1001;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst_serial4", 32'(so4), 32'd1);
      chk("midrst_busy4",   32'(busy4), 32'd0);
      chk("midrst_done4",   32'(done4), 32'd0);
      chk("midrst_busy1",   32'(busy1), 32'd0);
      step();
      @(negedge clock);
      reset = 1'b1;
      pulse_frame(4'b1010, 32);

      // Random start requests and present values, including changes mid-frame.
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         present = 4'($urandom_range(0, 15));
         step();
      end
      start = 1'b0;
      for (int i = 0; i < 30; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
